// File: rtl/uart_bit_timer_pkg.sv
// Shared definitions for the UART bit-timing engine.
//   - bt_state_e : engine state (IDLE, RUN)
//   - CLK_HZ, DIV_115200, DIV_9600 : reference clock and common bit-period divisors
//   - DEF_FRAME_BITS : default bits per frame (start + 8 data + stop)
package uart_bit_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bt_state_e;

  localparam int CLK_HZ         = 50_000_000;
  localparam int DIV_115200     = 434;
  localparam int DIV_9600       = 5208;
  localparam int DEF_FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer_if.sv
// Control/status bundle between a UART RX/TX controller and its bit timer.
//   master (controller): drives start, abort, div; observes busy, sample_tick,
//                        bit_tick, bit_idx, done
//   slave  (bit timer) : the reverse
interface uart_bit_timer_if
  import uart_bit_timer_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int IDX_W = $clog2(DEF_FRAME_BITS)
);

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic             busy;
  logic             sample_tick;
  logic             bit_tick;
  logic [IDX_W-1:0] bit_idx;
  logic             done;

  modport master (
    output start, abort, div,
    input  busy, sample_tick, bit_tick, bit_idx, done
  );

  modport slave (
    input  start, abort, div,
    output busy, sample_tick, bit_tick, bit_idx, done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Runtime-programmable UART bit-timing engine.
// Times FRAME_BITS bits of div_q sysclk cycles each, giving one mid-bit
// sample_tick and one end-of-bit bit_tick per bit, and a done strobe on the
// last bit_tick of the frame.
//   sysclk : system clock
//   rst    : synchronous, active-high reset
//   bus    : uart_bit_timer_if slave (start/abort/div in; busy, sample_tick,
//            bit_tick, bit_idx, done out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs low
// RUN   | timing bits; cnt_q counts cycles within the bit, bit_idx_q the bit
module uart_bit_timer
  import uart_bit_timer_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1
) (
  input logic             sysclk,
  input logic             rst,
  uart_bit_timer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(2);

  bt_state_e        state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic [DIV_W-1:0] cnt_q;
  logic [IDX_W-1:0] bit_idx_q;

  logic run;
  logic at_mid;
  logic at_end;
  logic last_bit;

  // A period below 2 cannot place a mid-bit sample distinct from the bit
  // start, so such requests run at the minimum period instead.
  assign div_d    = (bus.div < MIN_DIV) ? MIN_DIV : bus.div;

  assign run      = (state_q == RUN);
  assign at_mid   = (cnt_q == (div_q >> 1));
  assign at_end   = (cnt_q == (div_q - DIV_W'(1)));
  assign last_bit = (bit_idx_q == LAST_IDX);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= MIN_DIV;
      cnt_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q   <= RUN;
            div_q     <= div_d;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end else if (at_end) begin
            cnt_q <= '0;
            if (last_bit) begin
              state_q   <= IDLE;
              bit_idx_q <= '0;
            end else begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes are decodes of the current registers, so an abort still lets
  // this cycle's ticks through while suppressing everything after it.
  assign bus.busy        = run;
  assign bus.sample_tick = run && at_mid;
  assign bus.bit_tick    = run && at_end;
  assign bus.bit_idx     = bit_idx_q;
  assign bus.done        = run && at_end && last_bit;

endmodule
